// File: rtl/frac_lutk_cfg.sv
// K-input fracturable LUT whose truth table and fracture-mode bit are loaded through a serial chain.
// Optional macro FRAC_LUT_OUT_FF_EN registers the LUT outputs behind lut_ce.
module frac_lutk_cfg #(
  parameter int K = 4,
  localparam int TT_BITS = 2 ** K,
  localparam int CFG_BITS = TT_BITS + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_din,
  output logic         cfg_dout,
  output logic         cfg_done,
  input  logic [K-1:0] lut_in,
  input  logic         lut_ce,
  output logic         lut_full_out,
  output logic [1:0]   lut_frac_out
);

  localparam int CNT_W = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS - 1);

  typedef enum logic [1:0] {UNCFG, LOAD, READY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic                done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNCFG;
      cnt_q   <= '0;
      sr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      done_q  <= done_d;
    end
  end

  // A start request always wins over a coincident data bit; a restart keeps sr contents.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    case (state_q)
      UNCFG: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          sr_d = {sr_q[CFG_BITS-2:0], cfg_din};
          if (cnt_q == LAST_CNT) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      READY: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = UNCFG;
        cnt_d   = '0;
      end
    endcase
    done_d = (state_d == READY);
  end

  assign cfg_dout = sr_q[CFG_BITS-1];
  assign cfg_done = done_q;

  logic [TT_BITS-1:0] tt;
  logic [K-2:0]       lo;
  logic               frac_mode, f0, f1, full;
  logic               full_g;
  logic [1:0]         frac_g;

  // tt is stored MSB-first, so address a selects tt[TT_BITS-1-a]; ~lo gives the reversed index.
  assign tt        = sr_q[TT_BITS-1:0];
  assign frac_mode = sr_q[CFG_BITS-1];
  assign lo        = lut_in[K-2:0];
  assign f0        = tt[{1'b0, ~lo}];
  assign f1        = tt[{1'b1, ~lo}];
  assign full      = lut_in[K-1] ? f0 : f1;

  assign full_g = done_q & full;
  assign frac_g = (done_q && frac_mode) ? {f1, f0} : 2'b00;

`ifdef FRAC_LUT_OUT_FF_EN
  logic       full_p1;
  logic [1:0] frac_p1;

  // Output register stage; a new load empties it straight away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_p1 <= 1'b0;
      frac_p1 <= 2'b00;
    end else if (cfg_start) begin
      full_p1 <= 1'b0;
      frac_p1 <= 2'b00;
    end else if (lut_ce) begin
      full_p1 <= full_g;
      frac_p1 <= frac_g;
    end
  end

  assign lut_full_out = full_p1;
  assign lut_frac_out = frac_p1;
`else
  logic unused_lut_ce;
  assign unused_lut_ce = lut_ce;

  assign lut_full_out = full_g;
  assign lut_frac_out = frac_g;
`endif

endmodule
